sprite_linebuf_ctrl: RTL and testbench

Controller for a ping-pong sprite line buffer built on a true dual-port RAM (`dpram`, `widthad_a = LINE_BITS+1`, `DATA_WIDTH = PIX_W`). It accepts a stream of sprite pixels for line N+1 and writes them into the draw bank through RAM port A with first-wins priority. In parallel, it scans out line N from the other bank through port B and clears each location behind the read. It sits between the sprite rasterizer (upstream) and the video mixer (downstream).

---
 rtl/sprite_linebuf_ctrl.sv | 134 +++++++++++++
 tb/tb_sprite_linebuf_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_linebuf_ctrl.sv
// Ping-pong sprite line buffer controller: first-wins draw into one bank on port A,
// scan-out with clear-behind from the other bank on port B.
module sprite_linebuf_ctrl #(
    parameter int LINE_BITS = 8,
    parameter int PIX_W     = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic                 ce_pix,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [LINE_BITS-1:0] pix_x,
    input  logic [PIX_W-1:0]     pix_color,
    output logic [LINE_BITS:0]   ram_addr_a,
    output logic [PIX_W-1:0]     ram_data_a,
    output logic                 ram_wren_a,
    input  logic [PIX_W-1:0]     ram_q_a,
    output logic [LINE_BITS:0]   ram_addr_b,
    output logic [PIX_W-1:0]     ram_data_b,
    output logic                 ram_wren_b,
    input  logic [PIX_W-1:0]     ram_q_b,
    output logic [PIX_W-1:0]     pix_out,
    output logic                 pix_out_valid
);

    typedef enum logic [1:0] {D_IDLE, D_RD, D_CHK} dstate_t;
    typedef enum logic {S_IDLE, S_CLR} sstate_t;

    dstate_t              dstate_q, dstate_d;
    sstate_t              sstate_q, sstate_d;
    logic                 bank_q, bank_d;
    logic                 wbank_q, wbank_d;
    logic                 ready_q, ready_d;
    logic [LINE_BITS-1:0] x_q, x_d;
    logic [LINE_BITS-1:0] hcnt_q, hcnt_d;
    logic [PIX_W-1:0]     color_q, color_d;
    logic [LINE_BITS:0]   saddr_q, saddr_d;
    logic [PIX_W-1:0]     pix_out_q, pix_out_d;
    logic                 out_valid_q, out_valid_d;
    logic [LINE_BITS:0]   scan_addr;
    logic                 accept;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dstate_q    <= D_IDLE;
            sstate_q    <= S_IDLE;
            bank_q      <= 1'b0;
            wbank_q     <= 1'b0;
            ready_q     <= 1'b0;
            x_q         <= '0;
            hcnt_q      <= '0;
            color_q     <= '0;
            saddr_q     <= '0;
            pix_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dstate_q    <= dstate_d;
            sstate_q    <= sstate_d;
            bank_q      <= bank_d;
            wbank_q     <= wbank_d;
            ready_q     <= ready_d;
            x_q         <= x_d;
            hcnt_q      <= hcnt_d;
            color_q     <= color_d;
            saddr_q     <= saddr_d;
            pix_out_q   <= pix_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Draw path: read-check-write so the first opaque pixel at an x wins.
    always_comb begin
        dstate_d = dstate_q;
        x_d      = x_q;
        color_d  = color_q;
        wbank_d  = wbank_q;
        accept   = pix_valid && ready_q && (dstate_q == D_IDLE);
        unique case (dstate_q)
            D_IDLE: begin
                if (accept) begin
                    x_d     = pix_x;
                    color_d = pix_color;
                    wbank_d = bank_q;
                    if (pix_color != '0) dstate_d = D_RD;
                end
            end
            D_RD:    dstate_d = D_CHK;
            D_CHK:   dstate_d = D_IDLE;
            default: dstate_d = D_IDLE;
        endcase
        ready_d = (dstate_d == D_IDLE);
    end

    assign pix_ready  = ready_q;
    assign ram_addr_a = {wbank_q, x_q};
    assign ram_data_a = color_q;
    assign ram_wren_a = (dstate_q == D_CHK) && (ram_q_a == '0);

    // A coincident line_start already selects the new scan bank at address 0.
    always_comb begin
        bank_d      = bank_q ^ line_start;
        hcnt_d      = line_start ? '0 : hcnt_q;
        sstate_d    = sstate_q;
        saddr_d     = saddr_q;
        pix_out_d   = pix_out_q;
        out_valid_d = 1'b0;
        ram_wren_b  = 1'b0;
        scan_addr   = line_start ? {bank_q, {LINE_BITS{1'b0}}} : {~bank_q, hcnt_q};
        ram_addr_b  = saddr_q;
        unique case (sstate_q)
            S_IDLE: begin
                if (ce_pix) begin
                    ram_addr_b = scan_addr;
                    saddr_d    = scan_addr;
                    sstate_d   = S_CLR;
                end
            end
            S_CLR: begin
                pix_out_d   = ram_q_b;
                out_valid_d = 1'b1;
                ram_wren_b  = 1'b1;
                if (!line_start) hcnt_d = hcnt_q + LINE_BITS'(1);
                sstate_d    = S_IDLE;
            end
            default: sstate_d = S_IDLE;
        endcase
    end

    assign ram_data_b    = '0;
    assign pix_out       = pix_out_q;
    assign pix_out_valid = out_valid_q;

endmodule

// File: tb/tb_sprite_linebuf_ctrl.sv
// Scoreboard bench for sprite_linebuf_ctrl with a behavioural dual-port RAM.
module tb_sprite_linebuf_ctrl;
    localparam int LB = 8;
    localparam int PW = 8;
    localparam int N  = 256;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          line_start = 1'b0;
    logic          ce_pix = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [LB-1:0] pix_x = '0;
    logic [PW-1:0] pix_color = '0;
    logic [LB:0]   ram_addr_a, ram_addr_b;
    logic [PW-1:0] ram_data_a, ram_data_b;
    logic          ram_wren_a, ram_wren_b;
    logic [PW-1:0] ram_q_a = '0;
    logic [PW-1:0] ram_q_b = '0;
    logic [PW-1:0] pix_out;
    logic          pix_out_valid;

    logic [PW-1:0] mem [0:2*N-1] = '{default: 8'h00};

    int vec_cnt = 0;
    int err_cnt = 0;
    int wren_a_cnt = 0;
    int w0;
    logic [PW-1:0] exp_line [0:N-1];
    logic [PW-1:0] exp_q [$];
    int            idx_q [$];

    sprite_linebuf_ctrl #(.LINE_BITS(LB), .PIX_W(PW)) dut (
        .clk_sys(clk_sys), .reset(reset), .line_start(line_start), .ce_pix(ce_pix),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_color(pix_color),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a), .ram_q_a(ram_q_a),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_wren_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_wren_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected scan-out pixel whenever the DUT strobes one.
    always @(negedge clk_sys) begin
        if (ram_wren_a === 1'b1) wren_a_cnt++;
        if (pix_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected pix_out_valid", 32'd1, 32'd0);
            end else begin
                logic [PW-1:0] e;
                int            i;
                e = exp_q.pop_front();
                i = idx_q.pop_front();
                vec_cnt++;
                if (pix_out !== e) begin
                    err_cnt++;
                    $display("FAIL pix_out[%0d]: got %02h expected %02h", i, pix_out, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_sys);
        while (pix_ready !== 1'b1 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (pix_ready !== 1'b1) check("pix_ready timeout", {31'd0, pix_ready}, 32'd1);
    endtask

    task automatic draw(input logic [LB-1:0] x, input logic [PW-1:0] c);
        wait_ready();
        pix_valid = 1'b1;
        pix_x     = x;
        pix_color = c;
        @(posedge clk_sys);
        #1 pix_valid = 1'b0;
    endtask

    task automatic pulse_ls();
        @(negedge clk_sys) line_start = 1'b1;
        @(negedge clk_sys) line_start = 1'b0;
    endtask

    task automatic set_exp(input logic [PW-1:0] v);
        for (int i = 0; i < N; i++) exp_line[i] = v;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check("scoreboard drain", exp_q.size(), 32'd0);
    endtask

    task automatic scan_line();
        for (int i = 0; i < N; i++) begin
            @(negedge clk_sys) ce_pix = 1'b1;
            exp_q.push_back(exp_line[i]);
            idx_q.push_back(i);
            @(negedge clk_sys) ce_pix = 1'b0;
        end
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pix_ready"}, {31'd0, pix_ready}, 32'd0);
        check({tag, " pix_out_valid"}, {31'd0, pix_out_valid}, 32'd0);
        check({tag, " pix_out"}, {24'd0, pix_out}, 32'd0);
        check({tag, " ram_wren_a"}, {31'd0, ram_wren_a}, 32'd0);
        check({tag, " ram_wren_b"}, {31'd0, ram_wren_b}, 32'd0);
        check({tag, " ram_addr_a"}, {23'd0, ram_addr_a}, 32'd0);
        check({tag, " ram_addr_b"}, {23'd0, ram_addr_b}, 32'd0);
        check({tag, " ram_data_a"}, {24'd0, ram_data_a}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk_sys);
        check_reset_outputs("reset");
        @(negedge clk_sys) reset = 1'b0;
        @(negedge clk_sys);
        check("pix_ready after reset", {31'd0, pix_ready}, 32'd1);

        // Basic: one opaque pixel at x=5
        draw(8'd5, 8'h3C);
        idle(4);
        check("basic wren_a count", wren_a_cnt, 32'd1);
        pulse_ls();
        set_exp(8'h00);
        exp_line[5] = 8'h3C;
        scan_line();

        // Priority: first opaque write at x=10 wins
        w0 = wren_a_cnt;
        draw(8'd10, 8'h11);
        draw(8'd10, 8'h22);
        idle(4);
        check("priority wren_a count", wren_a_cnt - w0, 32'd1);
        pulse_ls();
        set_exp(8'h00);
        exp_line[10] = 8'h11;
        scan_line();

        // Transparent pixels accepted back to back, nothing written
        w0 = wren_a_cnt;
        wait_ready();
        pix_valid = 1'b1;
        pix_x     = 8'd7;
        pix_color = 8'h00;
        @(negedge clk_sys);
        check("transparent ready 1", {31'd0, pix_ready}, 32'd1);
        pix_x = 8'd8;
        @(negedge clk_sys);
        check("transparent ready 2", {31'd0, pix_ready}, 32'd1);
        pix_valid = 1'b0;
        idle(3);
        check("transparent wren_a count", wren_a_cnt - w0, 32'd0);

        // Clear-behind: fill, scan, swap twice, rescan empty
        for (int x = 0; x < N; x++) draw(x[LB-1:0], 8'hFF);
        idle(4);
        pulse_ls();
        set_exp(8'hFF);
        scan_line();
        pulse_ls();
        pulse_ls();
        set_exp(8'h00);
        scan_line();

        // line_start during RD: write lands in the latched (old) bank
        draw(8'd255, 8'h44);
        @(negedge clk_sys) line_start = 1'b1;
        @(negedge clk_sys) line_start = 1'b0;
        idle(3);
        set_exp(8'h00);
        exp_line[255] = 8'h44;
        scan_line();

        // line_start coincident with ce_pix reads new scan bank at address 0
        draw(8'd0, 8'h5A);
        idle(4);
        @(negedge clk_sys);
        ce_pix = 1'b1;
        line_start = 1'b1;
        exp_q.push_back(8'h5A);
        idx_q.push_back(0);
        @(negedge clk_sys);
        ce_pix = 1'b0;
        line_start = 1'b0;
        @(negedge clk_sys) ce_pix = 1'b1;
        exp_q.push_back(8'h00);
        idx_q.push_back(1);
        @(negedge clk_sys) ce_pix = 1'b0;
        drain();

        // Reset in CHK aborts the write asynchronously
        draw(8'd3, 8'h77);
        @(posedge clk_sys);
        #2;
        check("chk wren_a before reset", {31'd0, ram_wren_a}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid-chk reset");
        @(negedge clk_sys) reset = 1'b0;
        @(negedge clk_sys);
        check("pix_ready after mid reset", {31'd0, pix_ready}, 32'd1);
        pulse_ls();
        pulse_ls();
        set_exp(8'h00);
        scan_line();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
